crc_frame_checker: RTL and testbench
====================================

# crc_frame_checker

Serial-input CRC frame receiver for the FEC datapath. It accepts a bitstream one bit per handshake, MSB first: DATA_WIDTH payload bits followed by CRC_WIDTH check bits. It deserializes the payload, computes the CRC on the fly, and presents the payload word plus a pass/fail flag on a valid/ready output port. It is the receive-side counterpart of the parallel CRC generator and serializer on the transmit path.

## Interface
- DATA_WIDTH, 12, payload bits per frame (≥1)
- CRC_WIDTH, 4, check bits per frame (≥1)
- POLY, 5'b10011, generator polynomial (CRC_WIDTH+1 bits); only POLY[CRC_WIDTH-1:0] is used as the feedback mask
- SEED, '0, CRC register value at frame start
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- bit_in  in  1  serial data bit
- bit_sof  in  1  marks bit_in as the first payload bit of a frame
- bit_valid  in  1  bit_in/bit_sof valid
- bit_ready  out  1  checker can accept a bit
- data_out  out  DATA_WIDTH  received payload, first bit received in MSB
- crc_ok  out  1  1 = received check bits equal the computed CRC
- out_valid  out  1  data_out/crc_ok valid
- out_ready  in  1  downstream accepts result
- busy  out  1  frame in progress (state is S_DATA or S_CRC)

## Operation
- A bit is accepted when bit_valid && bit_ready.
- bit_ready = (state != S_OUT). It is combinational from state and is therefore 1 out of reset.
- FSM states: S_IDLE, S_DATA, S_CRC, S_OUT.
- **S_IDLE:**
  - Accepted bit with bit_sof=1: CRC register is loaded with SEED and stepped with bit_in. The bit is shifted into the payload register. Counter is set to DATA_WIDTH-1, then go to S_DATA. If DATA_WIDTH=1, go directly to S_CRC with counter = CRC_WIDTH.
  - Accepted bit with bit_sof=0: discarded, stay in S_IDLE.
- **S_DATA:** each accepted bit steps the CRC and shifts into the payload register; counter is decremented. The accepted bit that makes the counter 0 moves to S_CRC with counter = CRC_WIDTH.
- **CRC step:** fb = bit_in ^ crc[CRC_WIDTH-1]; crc = (crc << 1) ^ (fb ? POLY[CRC_WIDTH-1:0] : 0).
- **S_CRC:** accepted bits shift into a received-CRC register (CRC is not stepped). On the last check bit:
  - data_out gets the payload register;
  - crc_ok gets (received CRC == computed CRC);
  - out_valid is set to 1;
  - next state is S_OUT.
- **S_OUT:** hold data_out, crc_ok and out_valid. On out_valid && out_ready, clear out_valid and go to S_IDLE.
- **Resync:** an accepted bit with bit_sof=1 in S_DATA or S_CRC aborts the partial frame. That bit is processed exactly as the first bit from S_IDLE. No output is produced for the aborted frame.
- data_out and crc_ok hold their values until overwritten by the next completed frame.
- **Reset values:** out_valid=0, data_out=0, crc_ok=0, busy=0, state=S_IDLE, internal registers 0.

## Timing
- Frame length: DATA_WIDTH+CRC_WIDTH accepted bits. Gaps (bit_valid=0) are allowed anywhere without effect.
- Latency: last check bit accepted at edge N, out_valid=1 after edge N. One cycle of registered latency.
- Back-pressure: bit_ready=0 for every cycle out_valid=1.
- After the output handshake at edge M, bit_ready=1 after M. Minimum frame-to-frame spacing is therefore DATA_WIDTH+CRC_WIDTH+1 cycles.
- bit_sof is ignored in S_OUT because no bit is accepted there.
- rst_n asserted mid-frame or in S_OUT returns everything to reset values immediately. The partial or pending frame is lost.

## Configuration
- Macro: CRC_FRAME_CHECKER_ERR_CNT_EN.
- **Defined:** adds output port err_cnt, 16 bits, reset 0. It increments by 1 on each output handshake with crc_ok=0, saturates at 16'hFFFF, and is cleared only by reset.
- **Undefined:** the port and counter do not exist. All other behaviour is identical.

## Structure
- Shared package crc_pkg holds:
  - the state_t enum (S_IDLE, S_DATA, S_CRC, S_OUT, logic [1:0]);
  - function crc_step(crc, bit, poly), reused by the generator side.
- One sub-module, crc_bit_lfsr: serial LFSR with parameters CRC_WIDTH/POLY/SEED and ports clk, rst_n, load (load SEED and step), en (step), bit_in, crc.
- The top level holds the FSM, counter, shift registers and output port.

## Test plan
- Defaults; send sof + 12'hABC then 4'hA; out_ready=1 → after one cycle, out_valid=1, data_out=12'hABC, crc_ok=1, one-cycle pulse.
- Same frame with check bits 4'hB → data_out=12'hABC, crc_ok=0; with the macro defined, err_cnt=1.
- All-zero payload with check bits 4'h0 → crc_ok=1. Random bit_valid gaps inside the frame give an identical result.
- Hold out_ready=0 for 5 cycles after completion → out_valid and data_out stable, bit_ready=0, offered bits not consumed. Handshake → bit_ready=1 the next cycle.
- Send 7 bits of one frame, then sof + full 0xABC/0xA frame → exactly one output, 12'hABC with crc_ok=1. Bits without sof while idle produce no output.
- Assert rst_n low after 9 bits of a frame → all outputs return to 0, busy=0. The next full frame is checked correctly.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC definitions: receive FSM state encoding and a single serial CRC step.
// crc_step operands are MSB-aligned in CRC_MAX_W bits so one function serves any CRC width.
package crc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_OUT} state_t;

  localparam int CRC_MAX_W = 32;

  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 bit_i,
    input logic [CRC_MAX_W-1:0] poly
  );
    logic fb;
    fb = bit_i ^ crc[CRC_MAX_W-1];
    return (crc << 1) ^ (fb ? poly : '0);
  endfunction
endpackage

// File: rtl/crc_bit_lfsr.sv
// Serial CRC LFSR: load restarts from SEED and consumes bit_in, en consumes bit_in.
module crc_bit_lfsr
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH = 4,
  parameter logic [CRC_WIDTH:0]   POLY      = 5'b10011,
  parameter logic [CRC_WIDTH-1:0] SEED      = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc
);
  localparam int SH = CRC_MAX_W - CRC_WIDTH;

  logic [CRC_WIDTH-1:0] crc_q, crc_d, base;
  logic [CRC_MAX_W-1:0] stepped;

  always_comb begin
    base    = load ? SEED : crc_q;
    // Left-align so the package step sees the CRC MSB at its top bit.
    stepped = crc_step(CRC_MAX_W'(base) << SH, bit_in,
                       CRC_MAX_W'(POLY[CRC_WIDTH-1:0]) << SH);
    crc_d   = crc_q;
    if (load || en) crc_d = CRC_WIDTH'(stepped >> SH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/crc_frame_checker.sv
// Serial CRC frame receiver: payload then check bits, MSB first; reports payload and CRC pass/fail.
// Optional CRC_FRAME_CHECKER_ERR_CNT_EN adds a saturating 16-bit err_cnt of failed frames.
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 12,
  parameter int                   CRC_WIDTH  = 4,
  parameter logic [CRC_WIDTH:0]   POLY       = 5'b10011,
  parameter logic [CRC_WIDTH-1:0] SEED       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_in,
  input  logic                  bit_sof,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  crc_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
  ,output logic [15:0]          err_cnt
`endif
);
  localparam int CNT_MAX = (DATA_WIDTH - 1 > CRC_WIDTH) ? DATA_WIDTH - 1 : CRC_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] payload_q, payload_d, payload_sh;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CRC_WIDTH-1:0]  rcrc_q, rcrc_d, rcrc_sh;
  logic                  crc_ok_q, crc_ok_d;
  logic                  out_valid_q, out_valid_d;
  logic                  accept, lfsr_load, lfsr_en;
  logic [CRC_WIDTH-1:0]  crc_calc;

  crc_bit_lfsr #(.CRC_WIDTH(CRC_WIDTH), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .en     (lfsr_en),
    .bit_in (bit_in),
    .crc    (crc_calc)
  );

  assign bit_ready  = (state_q != S_OUT);
  assign accept     = bit_valid && bit_ready;
  assign payload_sh = (payload_q << 1) | DATA_WIDTH'(bit_in);
  assign rcrc_sh    = (rcrc_q << 1) | CRC_WIDTH'(bit_in);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    rcrc_d      = rcrc_q;
    data_out_d  = data_out_q;
    crc_ok_d    = crc_ok_q;
    out_valid_d = out_valid_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    // A sof bit starts a new frame from any accepting state, discarding a partial one.
    if (accept && bit_sof) begin
      lfsr_load = 1'b1;
      payload_d = payload_sh;
      if (DATA_WIDTH == 1) begin
        state_d = S_CRC;
        cnt_d   = CNT_W'(CRC_WIDTH);
      end else begin
        state_d = S_DATA;
        cnt_d   = CNT_W'(DATA_WIDTH - 1);
      end
    end else begin
      case (state_q)
        S_DATA: if (accept) begin
          lfsr_en   = 1'b1;
          payload_d = payload_sh;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_CRC;
            cnt_d   = CNT_W'(CRC_WIDTH);
          end
        end
        S_CRC: if (accept) begin
          rcrc_d = rcrc_sh;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            data_out_d  = payload_q;
            crc_ok_d    = (rcrc_sh == crc_calc);
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end
        end
        S_OUT: if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      payload_q   <= '0;
      rcrc_q      <= '0;
      data_out_q  <= '0;
      crc_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      rcrc_q      <= rcrc_d;
      data_out_q  <= data_out_d;
      crc_ok_q    <= crc_ok_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign crc_ok    = crc_ok_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_DATA) || (state_q == S_CRC);

`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && !crc_ok_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker: vector table, random frames, multi-cycle corner cases.
module tb_crc_frame_checker;
  localparam int DW = 12;
  localparam int CW = 4;
  localparam int GEN = 5'b10011;

  logic clk = 0, rst_n = 0;
  logic bit_in = 0, bit_sof = 0, bit_valid = 0, out_ready = 1;
  logic bit_ready, crc_ok, out_valid, busy;
  logic [DW-1:0] data_out;
`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  crc_frame_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_sof   (bit_sof),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .data_out  (data_out),
    .crc_ok    (crc_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
    ,.err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, hs_cnt = 0, exp_err = 0;

  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;

  typedef struct {
    logic [DW-1:0] pay;
    logic [CW-1:0] chk;
    bit            gaps;
    logic [DW-1:0] exp_data;
    bit            exp_ok;
  } vec_t;
  vec_t tbl[12];

  // Reference: remainder of payload * x^CW divided by the generator (seed 0).
  function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] d);
    int rem;
    rem = int'(d) << CW;
    for (int i = DW + CW - 1; i >= CW; i--)
      if (rem[i]) rem = rem ^ (GEN << (i - CW));
    return rem[CW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    int n = 0;
    bit_in = b; bit_sof = sof; bit_valid = 1;
    while (!bit_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bit_ready) begin
      checks++; errors++;
      $display("FAIL bit_accept_timeout actual=0 expected=1");
    end else begin
      @(posedge clk); #1;
    end
    bit_valid = 0; bit_sof = 0;
  endtask

  task automatic send_frame(input logic [DW-1:0] pay, input logic [CW-1:0] c, input bit gaps);
    logic b;
    for (int i = 0; i < DW + CW; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      b = (i < DW) ? pay[DW-1-i] : c[DW+CW-1-i];
      send_bit(b, i == 0);
    end
  endtask

  task automatic check_out(input string tag, input logic [DW-1:0] ed, input bit eok);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, data_out, ed);
    chk({tag, "_ok"}, crc_ok, eok);
    chk({tag, "_rdy_low"}, bit_ready, 0);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, out_valid, 0);
      chk({tag, "_rdy_back"}, bit_ready, 1);
      if (!eok && exp_err < 65535) exp_err++;
`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
      chk({tag, "_errcnt"}, err_cnt, exp_err);
`endif
    end
  endtask

  initial begin
    int hs0;
    logic [DW-1:0] d0;
    logic [CW-1:0] r;
    tbl[0] = '{12'hABC, 4'hA, 0, 12'hABC, 1};
    tbl[1] = '{12'hABC, 4'hB, 0, 12'hABC, 0};
    tbl[2] = '{12'h000, 4'h0, 0, 12'h000, 1};
    tbl[3] = '{12'h000, 4'h0, 1, 12'h000, 1};
    tbl[4] = '{12'hABC, 4'hA, 1, 12'hABC, 1};
    tbl[5] = '{12'hFFF, ref_crc(12'hFFF), 1, 12'hFFF, 1};
    for (int i = 6; i < 12; i++) begin
      tbl[i].pay = DW'($urandom);
      r = ref_crc(tbl[i].pay);
      tbl[i].chk = $urandom_range(0, 1) ? r : r ^ CW'($urandom_range(1, 15));
      tbl[i].gaps = $urandom_range(0, 1);
      tbl[i].exp_data = tbl[i].pay;
      tbl[i].exp_ok = (tbl[i].chk == r);
    end

    idle(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bit_ready, 1);
`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
    chk("rst_errcnt", err_cnt, 0);
`endif
    rst_n = 1;
    idle(1);

    for (int i = 0; i < 12; i++) begin
      send_frame(tbl[i].pay, tbl[i].chk, tbl[i].gaps);
      check_out($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_ok);
    end

    // Back-pressure: result held, bits refused while out_ready is low.
    out_ready = 0;
    send_frame(12'h5A3, ref_crc(12'h5A3), 0);
    d0 = 12'h5A3;
    check_out("bp", d0, 1);
    bit_in = 1; bit_sof = 1; bit_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", data_out, d0);
      chk("bp_hold_rdy", bit_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    bit_valid = 0; bit_sof = 0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_rdy", bit_ready, 1);
    chk("bp_not_consumed", busy, 0);

    // Resync: partial frame aborted by a new sof.
    hs0 = hs_cnt;
    for (int k = 0; k < 7; k++) send_bit($urandom_range(0, 1), k == 0);
    chk("rs_busy", busy, 1);
    chk("rs_novalid", out_valid, 0);
    send_frame(12'hABC, 4'hA, 0);
    check_out("rs", 12'hABC, 1);
    chk("rs_one_output", hs_cnt, hs0 + 1);

    // Bits without sof while idle are dropped.
    hs0 = hs_cnt;
    for (int k = 0; k < 20; k++) send_bit($urandom_range(0, 1), 0);
    idle(3);
    chk("nosof_busy", busy, 0);
    chk("nosof_valid", out_valid, 0);
    chk("nosof_outputs", hs_cnt, hs0);

    // Mid-frame reset.
    for (int k = 0; k < 9; k++) send_bit(1'b1, k == 0);
    rst_n = 0;
    #1;
    exp_err = 0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_ok", crc_ok, 0);
    chk("mrst_busy", busy, 0);
`ifdef CRC_FRAME_CHECKER_ERR_CNT_EN
    chk("mrst_errcnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);
    send_frame(12'hABC, 4'hA, 0);
    check_out("post_rst", 12'hABC, 1);
    send_frame(12'hABC, 4'hB, 1);
    check_out("post_rst_bad", 12'hABC, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
